stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, stack word width.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=4).
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 s_en  input  1  stack command qualifier; when 0 all other command inputs SHALL be ignored.
REQ-007 s_reset  input  1  flush stack (qualified by s_en).
REQ-008 s_en_op  input  1  explicit push/pop request.
REQ-009 s_op  input  1  1 = push, 0 = pop (valid when s_en_op=1).
REQ-010 s_en_noOpPop  input  1  operand-consume pop from an ALU instruction.
REQ-011 s_en_popQuantity  input  1  operand pops: 0 = one entry, 1 = two entries.
REQ-012 s_data_in  input  DATA_W  value to push (already muxed by the datapath).
REQ-013 s_top  output  DATA_W  entry at top of stack; 0 when empty.
REQ-014 s_top2  output  DATA_W  entry below top; 0 when count<2.
REQ-015 s_count  output  clog2(DEPTH)+1  current number of entries.
REQ-016 s_empty / s_full  output  1 each  count==0 / count==DEPTH.
REQ-017 s_ovf / s_unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-018 Command SHALL be evaluated once per cycle with s_en=1; effects SHALL be visible on all outputs the cycle after the edge (1-cycle latency).
REQ-019 Priority: s_reset > combined operation (REQ-022) > single operation; s_reset SHALL set count=0, clear s_ovf/s_unf; entry contents need not be cleared.
REQ-020 Push (s_en_op=1, s_op=1, s_en_noOpPop=0): write s_data_in at index count, count+1.
REQ-021 Pop: k = (s_en_op&~s_op) + (s_en_noOpPop ? 1+s_en_popQuantity : 0), k in 0..3; count-k.
REQ-022 Combined (s_en_op=1, s_op=1, s_en_noOpPop=1): pop k = 1+s_en_popQuantity entries, then push s_data_in at the new top in the same cycle; count' = count-k+1.
REQ-023 Underflow: if k > count, whole command SHALL be ignored (no push, count unchanged) and s_unf SHALL set.
REQ-024 Overflow: if resulting count would exceed DEPTH (push while full with k=0), command SHALL be ignored and s_ovf SHALL set; combined op on a full stack SHALL succeed (net <= 0).
REQ-025 s_ovf/s_unf SHALL remain set until rst or s_reset.
REQ-026 s_top/s_top2 SHALL be derived from registered count and storage only (no combinational path from command inputs).
REQ-027 s_count, s_empty, s_full SHALL be consistent every cycle; no wrap-around of count is permitted.
REQ-028 s_en=1 with no command bits set SHALL be a no-op.

Reset
REQ-029 On rst: count=0, s_empty=1, s_full=0, s_ovf=0, s_unf=0, s_top=0, s_top2=0; rst SHALL override any command in the same cycle, including mid-sequence operations.
REQ-030 Storage array SHALL NOT require reset.

Structure
REQ-031 Shared package nanorisc_pkg SHALL hold DATA_W, STK_DEPTH, and named constants for s_op push/pop encoding and pop quantities (ONE/TWO).
REQ-032 Storage SHALL be a sub-module stack_mem: DEPTH x DATA_W register array, one synchronous write port, two asynchronous read ports (top, top2).
REQ-033 Pointer/count arithmetic, flags and command decode SHALL reside in stack_unit.

Verification
REQ-034 After rst, push 0x11,0x22,0x33 -> s_count=3, s_top=0x33, s_top2=0x22, s_empty=0.
REQ-035 Stack {0x05,0x07} (top 0x07), combined op popQuantity=1, data 0x0C -> s_count=1, s_top=0x0C, s_top2=0.
REQ-036 Fill 16 entries, push 0xAA -> count stays 16, s_full=1, s_ovf=1, s_top unchanged; then combined op popQuantity=0 data 0x55 -> count 16, s_top=0x55.
REQ-037 Empty stack, noOpPop with popQuantity=1 -> count 0, s_unf=1; next s_reset -> s_unf=0.
REQ-038 Count=5, push asserted together with rst -> count=0, s_top=0, all flags 0; s_en=0 with push bits set -> no change.

Source files
------------

// File: rtl/nanorisc_pkg.sv
// Shared constants for the nanorisc datapath: word width, stack depth,
// command encodings and the pop-amount decode used by the stack unit.
package nanorisc_pkg;

    localparam int DATA_W    = 8;
    localparam int STK_DEPTH = 16;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    localparam logic POP_ONE = 1'b0;
    localparam logic POP_TWO = 1'b1;

    // Number of entries removed by one command (explicit pop plus operand pops), 0..3.
    function automatic logic [1:0] pop_count(
        input logic en_op,
        input logic op,
        input logic en_noop_pop,
        input logic pop_qty
    );
        logic [1:0] k;
        k = (en_op && (op == OP_POP)) ? 2'd1 : 2'd0;
        if (en_noop_pop) begin
            k = k + ((pop_qty == POP_TWO) ? 2'd2 : 2'd1);
        end else begin
            k = k;
        end
        return k;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x DATA_W register array, one synchronous write port
// and two asynchronous read ports for the top two entries.
module stack_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr_top,
    input  logic [$clog2(DEPTH)-1:0] raddr_top2,
    output logic [DATA_W-1:0]        rdata_top,
    output logic [DATA_W-1:0]        rdata_top2
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_top  = mem_r[raddr_top];
    assign rdata_top2 = mem_r[raddr_top2];

endmodule

// File: rtl/stack_unit.sv
// Hardware operand stack: command decode, count/flag tracking and top-of-stack
// presentation around a stack_mem storage array.
module stack_unit #(
    parameter int DATA_W = nanorisc_pkg::DATA_W,
    parameter int DEPTH  = nanorisc_pkg::STK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_en,
    input  logic                       s_reset,
    input  logic                       s_en_op,
    input  logic                       s_op,
    input  logic                       s_en_noOpPop,
    input  logic                       s_en_popQuantity,
    input  logic [DATA_W-1:0]          s_data_in,
    output logic [DATA_W-1:0]          s_top,
    output logic [DATA_W-1:0]          s_top2,
    output logic [$clog2(DEPTH):0]     s_count,
    output logic                       s_empty,
    output logic                       s_full,
    output logic                       s_ovf,
    output logic                       s_unf
);

    import nanorisc_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = CW + 1;

    logic [CW-1:0]     count_r;
    logic              ovf_r;
    logic              unf_r;

    logic [CW-1:0]     next_count_s;
    logic [EW-1:0]     result_s;
    logic [1:0]        k_s;
    logic [CW-1:0]     k_ext_s;
    logic              push_s;
    logic              we_s;
    logic [AW-1:0]     waddr_s;
    logic              flush_s;
    logic              set_ovf_s;
    logic              set_unf_s;
    logic [AW-1:0]     top_addr_s;
    logic [AW-1:0]     top2_addr_s;
    logic [DATA_W-1:0] rd_top_s;
    logic [DATA_W-1:0] rd_top2_s;

    // Command decode: a combined pop+push lands its write at count-k, which
    // also covers a plain push (k=0), so a single write address serves both.
    always_comb begin
        next_count_s = count_r;
        we_s         = 1'b0;
        waddr_s      = {AW{1'b0}};
        flush_s      = 1'b0;
        set_ovf_s    = 1'b0;
        set_unf_s    = 1'b0;
        k_s          = pop_count(s_en_op, s_op, s_en_noOpPop, s_en_popQuantity);
        push_s       = s_en_op & (s_op == OP_PUSH);
        k_ext_s      = {{(CW-2){1'b0}}, k_s};
        result_s     = {1'b0, count_r} - {1'b0, k_ext_s} + {{CW{1'b0}}, push_s};
        if (!rst && s_en) begin
            if (s_reset) begin
                flush_s = 1'b1;
            end else if (k_ext_s > count_r) begin
                set_unf_s = 1'b1;
            end else if (result_s > EW'(DEPTH)) begin
                set_ovf_s = 1'b1;
            end else begin
                next_count_s = result_s[CW-1:0];
                we_s         = push_s;
                waddr_s      = count_r[AW-1:0] - {{(AW-2){1'b0}}, k_s};
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // Count and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else if (flush_s) begin
            count_r <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            count_r <= next_count_s;
            ovf_r   <= ovf_r | set_ovf_s;
            unf_r   <= unf_r | set_unf_s;
        end
    end

    // Modular address arithmetic: a full stack (low bits 0) wraps to DEPTH-1.
    assign top_addr_s  = count_r[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
    assign top2_addr_s = count_r[AW-1:0] - {{(AW-2){1'b0}}, 2'b10};

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk        (clk),
        .we         (we_s),
        .waddr      (waddr_s),
        .wdata      (s_data_in),
        .raddr_top  (top_addr_s),
        .raddr_top2 (top2_addr_s),
        .rdata_top  (rd_top_s),
        .rdata_top2 (rd_top2_s)
    );

    assign s_top   = (count_r > {{(CW-1){1'b0}}, 1'b0}) ? rd_top_s  : {DATA_W{1'b0}};
    assign s_top2  = (count_r > {{(CW-1){1'b0}}, 1'b1}) ? rd_top2_s : {DATA_W{1'b0}};
    assign s_count = count_r;
    assign s_empty = (count_r == {CW{1'b0}});
    assign s_full  = (count_r == CW'(DEPTH));
    assign s_ovf   = ovf_r;
    assign s_unf   = unf_r;

endmodule

// File: tb/tb_stack_unit.sv
// Randomized self-checking bench for stack_unit against a queue-based model,
// plus directed scenarios for the documented corner cases.
module tb_stack_unit;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          s_en;
    logic          s_reset;
    logic          s_en_op;
    logic          s_op;
    logic          s_en_noOpPop;
    logic          s_en_popQuantity;
    logic [DW-1:0] s_data_in;
    logic [DW-1:0] s_top;
    logic [DW-1:0] s_top2;
    logic [4:0]    s_count;
    logic          s_empty;
    logic          s_full;
    logic          s_ovf;
    logic          s_unf;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] model_q [$];
    logic          m_ovf;
    logic          m_unf;

    stack_unit #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_en             (s_en),
        .s_reset          (s_reset),
        .s_en_op          (s_en_op),
        .s_op             (s_op),
        .s_en_noOpPop     (s_en_noOpPop),
        .s_en_popQuantity (s_en_popQuantity),
        .s_data_in        (s_data_in),
        .s_top            (s_top),
        .s_top2           (s_top2),
        .s_count          (s_count),
        .s_empty          (s_empty),
        .s_full           (s_full),
        .s_ovf            (s_ovf),
        .s_unf            (s_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: stack as a queue, commands either apply whole or not at all.
    task automatic model_step(input logic r, input logic en, input logic sr, input logic eop,
                              input logic op, input logic noop, input logic pq,
                              input logic [DW-1:0] d);
        int k;
        int push;
        if (r) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (en) begin
            if (sr) begin
                model_q.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                k = ((eop && !op) ? 1 : 0) + (noop ? (pq ? 2 : 1) : 0);
                push = (eop && op) ? 1 : 0;
                if (k > model_q.size()) begin
                    m_unf = 1'b1;
                end else if (model_q.size() - k + push > DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    for (int i = 0; i < k; i++) void'(model_q.pop_back());
                    if (push == 1) model_q.push_back(d);
                end
            end
        end
    endtask

    task automatic compare_all();
        int n;
        logic [DW-1:0] et;
        logic [DW-1:0] et2;
        n   = model_q.size();
        et  = (n > 0) ? model_q[n-1] : 8'h00;
        et2 = (n > 1) ? model_q[n-2] : 8'h00;
        check_eq("count", 32'(s_count), 32'(n));
        check_eq("top",   32'(s_top),   32'(et));
        check_eq("top2",  32'(s_top2),  32'(et2));
        check_eq("empty", 32'(s_empty), 32'(n == 0));
        check_eq("full",  32'(s_full),  32'(n == DEPTH));
        check_eq("ovf",   32'(s_ovf),   32'(m_ovf));
        check_eq("unf",   32'(s_unf),   32'(m_unf));
    endtask

    task automatic cmd(input logic r, input logic en, input logic sr, input logic eop,
                       input logic op, input logic noop, input logic pq,
                       input logic [DW-1:0] d);
        rst = r; s_en = en; s_reset = sr; s_en_op = eop; s_op = op;
        s_en_noOpPop = noop; s_en_popQuantity = pq; s_data_in = d;
        @(posedge clk);
        model_step(r, en, sr, eop, op, noop, pq, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_rst();
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic push(input logic [DW-1:0] d);
        cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic combined(input logic pq, input logic [DW-1:0] d);
        cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, pq, d);
    endtask

    initial begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
        rst = 1'b1; s_en = 1'b0; s_reset = 1'b0; s_en_op = 1'b0; s_op = 1'b0;
        s_en_noOpPop = 1'b0; s_en_popQuantity = 1'b0; s_data_in = 8'h00;

        // Reset state
        do_rst();
        check_eq("rst_count", 32'(s_count), 32'd0);
        check_eq("rst_empty", 32'(s_empty), 32'd1);

        // Three pushes
        push(8'h11); push(8'h22); push(8'h33);
        check_eq("p3_count", 32'(s_count), 32'd3);
        check_eq("p3_top",   32'(s_top),   32'h33);
        check_eq("p3_top2",  32'(s_top2),  32'h22);

        // Combined pop-two then push
        do_rst();
        push(8'h05); push(8'h07);
        combined(1'b1, 8'h0C);
        check_eq("comb_count", 32'(s_count), 32'd1);
        check_eq("comb_top",   32'(s_top),   32'h0C);
        check_eq("comb_top2",  32'(s_top2),  32'h00);

        // Overflow on a full stack, then combined op on full succeeds
        do_rst();
        for (int i = 0; i < DEPTH; i++) push(8'(i + 1));
        push(8'hAA);
        check_eq("ovf_count", 32'(s_count), 32'd16);
        check_eq("ovf_flag",  32'(s_ovf),   32'd1);
        check_eq("ovf_top",   32'(s_top),   32'h10);
        combined(1'b0, 8'h55);
        check_eq("fullcomb_top",   32'(s_top),   32'h55);
        check_eq("fullcomb_count", 32'(s_count), 32'd16);
        check_eq("ovf_sticky",     32'(s_ovf),   32'd1);

        // Underflow on empty, cleared by flush
        do_rst();
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        check_eq("unf_flag", 32'(s_unf), 32'd1);
        cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("unf_clr", 32'(s_unf), 32'd0);

        // rst beats a push; s_en=0 ignores command bits
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        cmd(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
        check_eq("rstpush_count", 32'(s_count), 32'd0);
        check_eq("rstpush_top",   32'(s_top),   32'd0);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        check_eq("noen_count", 32'(s_count), 32'd0);

        // Randomized traffic with phases biased toward filling and draining
        for (int i = 0; i < 1500; i++) begin
            logic r, en, sr, eop, op, noop, pq;
            int push_bias;
            push_bias = ((i / 100) % 2 == 0) ? 85 : 25;
            r    = ($urandom_range(0, 199) == 0);
            en   = ($urandom_range(0, 9) != 0);
            sr   = ($urandom_range(0, 79) == 0);
            eop  = ($urandom_range(0, 3) != 0);
            op   = ($urandom_range(0, 99) < push_bias);
            noop = ($urandom_range(0, 3) == 0);
            pq   = 1'($urandom_range(0, 1));
            cmd(r, en, sr, eop, op, noop, pq, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
